// File: rtl/fsm_cc8_sched_pkg.sv
// Shared types for the cc8 FSM scheduler: state encoding, idle output code, command fields.
package fsm_cc8_sched_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARB   = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam logic [2:0] FSM_IDLE_Y = 3'b000;

  localparam int CMD_SK_W = 2;
  localparam int CMD_W    = 1 + CMD_SK_W;
  localparam int HOLD_W   = 4;
  localparam int IDLE_W   = 3;
  localparam int TMO_W    = 10;

  typedef struct packed {
    logic jmp;
    logic sk1;
    logic sk0;
  } cmd_t;

endpackage

// File: rtl/fsm_cc8_sched_rr_arb.sv
// Combinational round-robin pick: first asserted req at or after ptr, wrapping; 0 latency.
module rr_arb
  import fsm_cc8_sched_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  win_oh,
  output logic [IDX_W-1:0] win_idx,
  output logic             win_vld
);

  logic [IDX_W-1:0] idx;

  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    win_vld = 1'b0;
    idx     = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = IDX_W'((int'(ptr) + i) % NREQ);
      if (!win_vld && req[idx]) begin
        win_vld      = 1'b1;
        win_oh[idx]  = 1'b1;
        win_idx      = idx;
      end
    end
  end

endmodule

// File: rtl/fsm_cc8_sched.sv
// Round-robin scheduler sharing one cc8 control FSM between NREQ requesters.
// FSM_CC8_SCHED_TIMEOUT_EN adds a WAIT-state timeout with a sticky err_tmo flag.
module fsm_cc8_sched
  import fsm_cc8_sched_pkg::*;
#(
  parameter int NREQ     = 2,
  parameter int HOLD_CYC = 4,
  parameter int IDLE_CYC = 2,
  parameter int TMO_CYC  = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   cmd_jmp,
  input  logic [2*NREQ-1:0] cmd_sk,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic              busy,
  input  logic [2:0]        fsm_y,
  output logic              go,
  output logic              jmp,
  output logic              sk0,
  output logic              sk1,
  output logic              err_tmo
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  cmd_t              cmd_q, cmd_d;
  cmd_t              out_q, out_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic              busy_q, busy_d;
  logic              go_q, go_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [IDLE_W-1:0] idle_q, idle_d;

  logic [NREQ-1:0]   arb_oh;
  logic [IDX_W-1:0]  arb_idx;
  logic              arb_vld;
  cmd_t              arb_cmd;

`ifdef FSM_CC8_SCHED_TIMEOUT_EN
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              err_q, err_d;
`endif

  rr_arb #(.NREQ(NREQ), .IDX_W(IDX_W)) u_arb (
    .req     (req),
    .ptr     (ptr_q),
    .win_oh  (arb_oh),
    .win_idx (arb_idx),
    .win_vld (arb_vld)
  );

  assign arb_cmd.jmp = cmd_jmp[arb_idx];
  assign arb_cmd.sk1 = cmd_sk[{arb_idx, 1'b1}];
  assign arb_cmd.sk0 = cmd_sk[{arb_idx, 1'b0}];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cmd_d   = cmd_q;
    out_d   = out_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    busy_d  = busy_q;
    go_d    = go_q;
    hold_d  = hold_q;
    idle_d  = idle_q;
`ifdef FSM_CC8_SCHED_TIMEOUT_EN
    tmo_d   = tmo_q;
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = ARB;
          busy_d  = 1'b1;
        end
      end
      ARB: begin
        if (arb_vld) begin
          state_d = ISSUE;
          gnt_d   = arb_oh;
          ptr_d   = (arb_idx == IDX_W'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
          cmd_d   = arb_cmd;
          out_d   = arb_cmd;
          go_d    = 1'b1;
          hold_d  = '0;
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      ISSUE: begin
        if (hold_q == HOLD_W'(HOLD_CYC - 1)) begin
          state_d = WAIT;
          go_d    = 1'b0;
          out_d   = '0;
          idle_d  = '0;
`ifdef FSM_CC8_SCHED_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end else begin
          hold_d  = hold_q + 1'b1;
        end
      end
      WAIT: begin
        // The settle run is judged on the count already registered, so a
        // completed run wins over a simultaneous timeout.
        if (idle_q == IDLE_W'(IDLE_CYC)) begin
          state_d = DONE;
          done_d  = gnt_q;
        end
`ifdef FSM_CC8_SCHED_TIMEOUT_EN
        else if (tmo_q == TMO_W'(TMO_CYC - 1)) begin
          state_d = DONE;
          done_d  = gnt_q;
          err_d   = 1'b1;
        end
`endif
        else begin
          idle_d  = (fsm_y == FSM_IDLE_Y) ? idle_q + 1'b1 : '0;
`ifdef FSM_CC8_SCHED_TIMEOUT_EN
          tmo_d   = tmo_q + 1'b1;
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
        go_d    = 1'b0;
        out_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cmd_q   <= '0;
      out_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      go_q    <= 1'b0;
      hold_q  <= '0;
      idle_q  <= '0;
`ifdef FSM_CC8_SCHED_TIMEOUT_EN
      tmo_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cmd_q   <= cmd_d;
      out_q   <= out_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      go_q    <= go_d;
      hold_q  <= hold_d;
      idle_q  <= idle_d;
`ifdef FSM_CC8_SCHED_TIMEOUT_EN
      tmo_q   <= tmo_d;
      err_q   <= err_d;
`endif
    end
  end

  assign gnt  = gnt_q;
  assign done = done_q;
  assign busy = busy_q;
  assign go   = go_q;
  assign jmp  = out_q.jmp;
  assign sk1  = out_q.sk1;
  assign sk0  = out_q.sk0;

`ifdef FSM_CC8_SCHED_TIMEOUT_EN
  assign err_tmo = err_q;
`else
  assign err_tmo = 1'b0;
`endif

endmodule

// File: tb/tb_fsm_cc8_sched.sv
// Randomized bench for fsm_cc8_sched against a transaction-level timing/arbitration model.
module tb_fsm_cc8_sched;

  localparam int NREQ = 3;
  localparam int HOLD = 4;
  localparam int IDLE = 2;
  localparam int TMO  = 8;
  localparam int SKW  = 2 * NREQ;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] cmd_jmp;
  logic [SKW-1:0]  cmd_sk;
  logic [NREQ-1:0] gnt;
  logic [NREQ-1:0] done;
  logic            busy;
  logic [2:0]      fsm_y;
  logic            go, jmp, sk0, sk1, err_tmo;

  int errs   = 0;
  int checks = 0;
  int ptr_m  = 0;
  bit err_m  = 1'b0;

  always #5 clk = ~clk;

  fsm_cc8_sched #(
    .NREQ(NREQ), .HOLD_CYC(HOLD), .IDLE_CYC(IDLE), .TMO_CYC(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .cmd_jmp(cmd_jmp), .cmd_sk(cmd_sk),
    .gnt(gnt), .done(done), .busy(busy), .fsm_y(fsm_y), .go(go), .jmp(jmp),
    .sk0(sk0), .sk1(sk1), .err_tmo(err_tmo)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] vec(input logic e, input logic b, input logic g,
                                      input logic [2:0] c, input logic [NREQ-1:0] d,
                                      input logic [NREQ-1:0] gg);
    return 32'({e, b, g, c, d, gg});
  endfunction

  function automatic logic [31:0] obs_vec();
    return vec(err_tmo, busy, go, {jmp, sk1, sk0}, done, gnt);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete request: drive mask in the current (idle) cycle and check every
  // cycle until the done pulse against the model's winner, command and timing.
  // ymode: 0 random, 1 all idle, 2 five cycles of 110 then idle, 3 glitch, 4 stuck 111.
  task automatic run_op(input logic [NREQ-1:0] mask, input int ymode, input bit wiggle);
    int w, d_off, wst, dly, j;
    int yq[64];
    bit tmo, z;
    logic [2:0] c;
    logic [NREQ-1:0] oh;
    req     = mask;
    cmd_jmp = NREQ'($urandom);
    cmd_sk  = SKW'($urandom);
    fsm_y   = 3'($urandom);
    w = -1;
    for (int i = 0; i < NREQ; i++)
      if (w < 0 && mask[(ptr_m + i) % NREQ]) w = (ptr_m + i) % NREQ;
    c  = {cmd_jmp[w], cmd_sk[2*w+1], cmd_sk[2*w]};
    oh = '0;
    oh[w] = 1'b1;
    ptr_m = (w + 1) % NREQ;
    for (int k = 0; k < 64; k++) begin
      case (ymode)
        0:       yq[k] = (k < 20 && $urandom_range(0, 2) == 0) ? int'($urandom_range(1, 7)) : 0;
        2:       yq[k] = (k < 5) ? 6 : 0;
        3:       yq[k] = (k == 1) ? 6 : 0;
        4:       yq[k] = 7;
        default: yq[k] = 0;
      endcase
    end
    // Done fires the cycle after IDLE consecutive idle samples have been seen in WAIT.
    d_off = -1;
    for (int k = IDLE + 1; k < 64 && d_off < 0; k++) begin
      z = 1'b1;
      for (int m = k - IDLE - 1; m <= k - 2; m++) if (yq[m] != 0) z = 1'b0;
      if (z) d_off = k;
    end
    tmo = 1'b0;
`ifdef FSM_CC8_SCHED_TIMEOUT_EN
    if (d_off < 0 || d_off > TMO) begin
      d_off = TMO;
      tmo   = 1'b1;
    end
`endif
    wst = 2 + HOLD;
    dly = wst + d_off;
    for (int k = 0; k <= dly; k++) begin
      if (tmo && k == dly) err_m = 1'b1;
      check($sformatf("op w%0d k%0d", w, k), obs_vec(),
            vec(err_m, k >= 1, (k >= 2 && k < 2 + HOLD),
                (k >= 2 && k < 2 + HOLD) ? c : 3'b000,
                (k == dly) ? oh : '0, (k >= 2) ? oh : '0));
      tick();
      if (k + 1 >= 2 && wiggle) begin
        req     = mask & NREQ'($urandom);
        cmd_jmp = NREQ'($urandom);
        cmd_sk  = SKW'($urandom);
      end
      j = k + 1 - wst;
      fsm_y = (j >= 0 && j < 64) ? 3'(yq[j]) : 3'($urandom);
    end
    req = '0;
  endtask

  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      req     = '0;
      cmd_jmp = NREQ'($urandom);
      cmd_sk  = SKW'($urandom);
      fsm_y   = 3'($urandom);
      check("idle", obs_vec(), vec(err_m, 1'b0, 1'b0, 3'b000, '0, '0));
      tick();
    end
  endtask

  task automatic reset_mid_issue();
    req     = 3'b001;
    cmd_jmp = 3'b111;
    cmd_sk  = '1;
    fsm_y   = 3'b000;
    tick();
    tick();
    tick();
    check("pre_rst_go", 32'({go, gnt}), 32'({1'b1, 3'b001}));
    rst_n = 1'b0;
    req   = '0;
    #1;
    check("rst_async", obs_vec(), 32'd0);
    tick();
    check("rst_hold", obs_vec(), 32'd0);
    ptr_m = 0;
    err_m = 1'b0;
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n   = 1'b0;
    req     = '0;
    cmd_jmp = '0;
    cmd_sk  = '0;
    fsm_y   = 3'b000;
    tick();
    tick();
    check("reset", obs_vec(), 32'd0);
    rst_n = 1'b1;
    tick();
    idle_gap(2);

    run_op(3'b001, 1, 1'b0);
    run_op(3'b011, 1, 1'b0);
    run_op(3'b011, 1, 1'b0);
    run_op(3'b011, 1, 1'b0);
    run_op(3'b110, 2, 1'b0);
    run_op(3'b111, 3, 1'b0);
    run_op(3'b100, 1, 1'b1);
    run_op(3'b101, 0, 1'b1);
    idle_gap(3);
    run_op(3'b111, 1, 1'b0);
    run_op(3'b111, 1, 1'b0);

    reset_mid_issue();
    run_op(3'b111, 1, 1'b0);

    for (int n = 0; n < 40; n++) begin
      run_op(NREQ'($urandom_range(1, (1 << NREQ) - 1)), int'($urandom_range(0, 3)),
             1'($urandom));
      if ($urandom_range(0, 3) == 0) idle_gap(int'($urandom_range(1, 3)));
    end

`ifdef FSM_CC8_SCHED_TIMEOUT_EN
    run_op(3'b010, 4, 1'b0);
    run_op(3'b011, 1, 1'b0);
    idle_gap(2);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/fsm_cc8_sched.md
Name: fsm_cc8_sched

Overview:
- Round-robin scheduler that shares one cc8-style control FSM (inputs go/jmp/sk0/sk1, outputs y1/y2/y3) between NREQ requesters.
- Each requester posts a command (jmp, sk1, sk0) and the scheduler grants one requester.
- It drives the FSM control inputs for a fixed hold window, waits for the FSM to settle idle, then signals done to the granted requester.
- Sits between requester logic and the FSM instance in the same clock domain.

Parameters:
- NREQ, 2: number of requesters; 2..8.
- HOLD_CYC, 4: cycles go and the command bits are held asserted; 1..15.
- IDLE_CYC, 2: consecutive cycles of y1=y2=y3=0 that count as FSM settled; 1..7.
- TMO_CYC, 64: WAIT-state cycle limit (used only with the optional feature); 2..1023.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req  in  NREQ  per-requester request level; held until done
- cmd_jmp  in  NREQ  per-requester jmp bit
- cmd_sk  in  2*NREQ  per-requester {sk1,sk0}; bits [2i+1:2i] belong to requester i
- gnt  out  NREQ  one-hot grant, high from ARB exit until DONE exit
- done  out  NREQ  one-cycle pulse to the granted requester at completion
- busy  out  1  high in any state except IDLE
- fsm_y  in  3  {y1,y2,y3} from the controlled FSM
- go  out  1  FSM go
- jmp  out  1  FSM jmp
- sk0  out  1  FSM sk0
- sk1  out  1  FSM sk1
- err_tmo  out  1  sticky timeout flag (optional feature; tied 0 otherwise)

Behaviour:
- Clock and reset: single clock clk; reset is asynchronous, active-low on rst_n.
- Reset values: all outputs 0; state IDLE; round-robin pointer 0; counters 0; latched command 0.
- State machine:
  - IDLE: if |req, go to ARB next cycle; otherwise stay.
  - ARB (1 cycle): pick the first asserted req at or after the pointer, wrapping. Latch that requester's cmd_jmp/cmd_sk into internal registers. Set gnt one-hot. Advance the pointer to winner+1 mod NREQ. If req dropped to 0 this cycle, return to IDLE with no grant.
  - ISSUE: go=1, jmp/sk1/sk0 = latched values, registered. Stay HOLD_CYC cycles via hold counter, then go to WAIT with go/jmp/sk0/sk1 deasserted on WAIT entry.
  - WAIT: count consecutive cycles with fsm_y==3'b000. Reset the count on any nonzero fsm_y. When the count reaches IDLE_CYC, go to DONE.
  - DONE (1 cycle): done[winner]=1; clear gnt at exit; return to IDLE.
- Latency: req to go asserted = 2 cycles (IDLE→ARB→ISSUE). Minimum req to done = 2+HOLD_CYC+IDLE_CYC+1.
- The latched command is stable through ISSUE even if cmd_* changes. Requester inputs are ignored outside ARB.
- If the granted requester drops req mid-operation, the sequence still completes and done still pulses (no abort).
- Simultaneous requests are resolved only by the round-robin pointer. A requester cannot win twice in a row while another is requesting.
- Pointer wraps NREQ-1→0.
- Reset mid-operation returns to IDLE asynchronously and drops go/gnt immediately.

Optional Feature:
- Macro: FSM_CC8_SCHED_TIMEOUT_EN.
- Defined:
  - A 10-bit WAIT counter counts cycles in WAIT.
  - Reaching TMO_CYC forces DONE, sets err_tmo (sticky until reset), and done still pulses.
- Undefined:
  - No counter; WAIT waits indefinitely; err_tmo tied 0.

Decomposition:
- Package fsm_cc8_sched_pkg: state enum (IDLE, ARB, ISSUE, WAIT, DONE, 3-bit binary); FSM_IDLE_Y = 3'b000; command field width constants.
- Sub-module rr_arb: combinational round-robin pick of a one-hot winner from req plus pointer, plus winner index output. Top holds the pointer register.

Test Plan:
- Single request: req=2'b01, cmd_jmp=0, cmd_sk=2'b01, fsm_y forced 000 → gnt=01 at cycle 2; go=1, sk0=1 for exactly 4 cycles; done[0] pulse at cycle 2+4+2+1=9; busy low after.
- Contention: req=2'b11 held across three operations → grants in order 0,1,0. No back-to-back grant to the same requester.
- Settle delay: during WAIT, fsm_y=3'b110 for 5 cycles, then 000 → done fires exactly IDLE_CYC+1 cycles after fsm_y returns to 000. A 000-110-000 glitch restarts the count.
- Command stability: change cmd_sk of the granted requester during ISSUE → sk0/sk1 keep the latched values.
- Reset mid-ISSUE: assert rst_n=0 on the 2nd hold cycle → go, gnt and busy drop to 0 immediately. After release, a new req is served from pointer 0.
- With FSM_CC8_SCHED_TIMEOUT_EN, fsm_y stuck at 3'b111, TMO_CYC=8 → done pulses after 8 WAIT cycles and err_tmo=1 stays set.
